fir_mac_mc: RTL and testbench

FIR_MAC_MC -- requirements
Module: fir_mac_mc

---
 rtl/fir_mac_pkg.sv | 71 +++++++
 rtl/fir_coef_bank.sv | 37 +++
 rtl/fir_mac_mc.sv | 181 ++++++++++++++++++
 tb/tb_fir_mac_mc.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_mac_pkg.sv
// Shared types and arithmetic helpers for the multi-channel FIR MAC.
// Holds the controller state encoding, the accumulator sizing rule and
// the round-half-up / clamp helpers used on the output path.
package fir_mac_pkg;

  // Controller states: wait for a sample, accumulate TAPS products, emit.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Working width for the output arithmetic; wide enough for any
  // accumulator this block is built with (DW+CW+clog2(TAPS) < 62).
  localparam int RS_W = 64;

  // Width of a channel index port; a single channel still gets one bit.
  function automatic int ch_width(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

  // Accumulator width that can hold TAPS full-scale products without wrap.
  function automatic int acc_width(input int dw, input int cw, input int taps);
    return dw + cw + $clog2(taps);
  endfunction

  // Drop the CW-1 fractional bits of a Qx.(CW-1) product sum, rounding half up.
  function automatic logic signed [RS_W-1:0] round_half_up(
    input logic signed [RS_W-1:0] acc,
    input int                     cw
  );
    return (acc + (64'sd1 <<< (cw - 2))) >>> (cw - 1);
  endfunction

  // True when the rounded value does not fit a signed dw-bit result.
  function automatic logic sat_flag(
    input logic signed [RS_W-1:0] acc,
    input int                     cw,
    input int                     dw
  );
    logic signed [RS_W-1:0] r;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    r  = round_half_up(acc, cw);
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    return (r > hi) || (r < lo);
  endfunction

  // Rounded value clamped to the signed dw-bit range.
  function automatic logic signed [RS_W-1:0] round_sat(
    input logic signed [RS_W-1:0] acc,
    input int                     cw,
    input int                     dw
  );
    logic signed [RS_W-1:0] r;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    r  = round_half_up(acc, cw);
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (r > hi) begin
      return hi;
    end else if (r < lo) begin
      return lo;
    end else begin
      return r;
    end
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Two-bank coefficient store: TAPS signed coefficients per bank, one
// write port and one asynchronous read port. Cleared by reset.
module fir_coef_bank
  import fir_mac_pkg::*;
#(
  parameter int CW   = 16,
  parameter int TAPS = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      we,
  input  logic                      wr_bank,
  input  logic [$clog2(TAPS)-1:0]   wr_addr,
  input  logic signed [CW-1:0]      wr_data,
  input  logic                      rd_bank,
  input  logic [$clog2(TAPS)-1:0]   rd_addr,
  output logic signed [CW-1:0]      rd_data
);

  logic signed [CW-1:0] mem_r [2][TAPS];

  // Coefficient array: cleared on reset, otherwise written one word per strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int t = 0; t < TAPS; t++) begin
          mem_r[b][t] <= {CW{1'b0}};
        end
      end
    end else if (we) begin
      mem_r[wr_bank][wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_bank][rd_addr];

endmodule

// File: rtl/fir_mac_mc.sv
// Time-multiplexed multi-channel FIR filter using a single multiplier.
// Each accepted sample is shifted into its channel's delay line, then
// TAPS products are accumulated one per cycle and the sum is rounded,
// clamped and presented with a one-cycle strobe. Coefficients come from
// one of two banks chosen per sample; writes to the bank in use while
// a result is being computed are refused and flagged.
module fir_mac_mc
  import fir_mac_pkg::*;
#(
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int TAPS = 32,
  parameter int CH   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ch_width(CH)-1:0]       in_ch,
  input  logic signed [DW-1:0]          x_in,
  input  logic                          bank_sel,
  input  logic                          coef_we,
  input  logic                          coef_bank,
  input  logic [$clog2(TAPS)-1:0]       coef_addr,
  input  logic signed [CW-1:0]          coef_data,
  output logic                          coef_err,
  output logic                          out_valid,
  output logic [ch_width(CH)-1:0]       out_ch,
  output logic signed [DW-1:0]          y_out,
  output logic                          sat
);

  localparam int CHW  = ch_width(CH);
  localparam int AW   = $clog2(TAPS);
  localparam int ACCW = acc_width(DW, CW, TAPS);
  localparam int PW   = DW + CW;
  localparam logic [CHW:0]  CH_LIM = (CHW + 1)'(CH);
  localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);

  state_t                    state_r;
  state_t                    state_s;
  logic [AW-1:0]             k_r;
  logic [CHW-1:0]            ch_r;
  logic                      bank_r;
  logic signed [ACCW-1:0]    acc_r;
  logic signed [DW-1:0]      line_r [CH][TAPS];

  logic                      ch_ok_s;
  logic                      take_s;
  logic                      last_s;
  logic                      conflict_s;
  logic                      coef_wr_s;
  logic signed [CW-1:0]      h_s;
  logic signed [DW-1:0]      x_s;
  logic signed [PW-1:0]      prod_s;
  logic signed [RS_W-1:0]    acc_ext_s;
  logic signed [DW-1:0]      y_s;
  logic                      sat_s;

  assign ch_ok_s = ({1'b0, in_ch} < CH_LIM);
  assign last_s  = (k_r == K_LAST);

  // A write may not touch the bank that the in-flight sample is reading.
  assign conflict_s = coef_we && (coef_bank == bank_r) && (state_r != IDLE);
  assign coef_wr_s  = coef_we && !conflict_s;

  fir_coef_bank #(
    .CW   (CW),
    .TAPS (TAPS)
  ) u_coef (
    .clk     (clk),
    .reset   (reset),
    .we      (coef_wr_s),
    .wr_bank (coef_bank),
    .wr_addr (coef_addr),
    .wr_data (coef_data),
    .rd_bank (bank_r),
    .rd_addr (k_r),
    .rd_data (h_s)
  );

  // Next-state logic: accept in IDLE, TAPS accumulate cycles, one output cycle.
  always_comb begin
    state_s = state_r;
    take_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid && ch_ok_s) begin
          take_s  = 1'b1;
          state_s = MAC;
        end else begin
          state_s = IDLE;
        end
      end
      MAC: begin
        if (last_s) begin
          state_s = OUT;
        end else begin
          state_s = MAC;
        end
      end
      OUT:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath: current tap product and the rounded/clamped result of the sum.
  always_comb begin
    x_s       = line_r[ch_r][k_r];
    prod_s    = PW'(x_s) * PW'(h_s);
    acc_ext_s = RS_W'(acc_r);
    y_s       = DW'(round_sat(acc_ext_s, CW, DW));
    sat_s     = sat_flag(acc_ext_s, CW, DW);
  end

  // Controller state, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      k_r       <= {AW{1'b0}};
      ch_r      <= {CHW{1'b0}};
      bank_r    <= 1'b0;
      acc_r     <= {ACCW{1'b0}};
      in_ready  <= 1'b1;
      coef_err  <= 1'b0;
      out_valid <= 1'b0;
      out_ch    <= {CHW{1'b0}};
      y_out     <= {DW{1'b0}};
      sat       <= 1'b0;
    end else begin
      state_r   <= state_s;
      in_ready  <= (state_s == IDLE);
      coef_err  <= conflict_s;
      out_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (take_s) begin
            ch_r   <= in_ch;
            bank_r <= bank_sel;
            acc_r  <= {ACCW{1'b0}};
            k_r    <= {AW{1'b0}};
          end
        end
        MAC: begin
          acc_r <= acc_r + ACCW'(prod_s);
          k_r   <= k_r + AW'(1);
        end
        OUT: begin
          out_valid <= 1'b1;
          out_ch    <= ch_r;
          y_out     <= y_s;
          sat       <= sat_s;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Per-channel delay lines: only the accepted sample's channel shifts.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        for (int t = 0; t < TAPS; t++) begin
          line_r[c][t] <= {DW{1'b0}};
        end
      end
    end else if (take_s) begin
      for (int c = 0; c < CH; c++) begin
        if (CHW'(c) == in_ch) begin
          for (int t = TAPS - 1; t > 0; t--) begin
            line_r[c][t] <= line_r[c][t-1];
          end
          line_r[c][0] <= x_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_mc.sv
// Scoreboard bench for fir_mac_mc: stimulus pushes expected results from a
// plain-arithmetic reference model, a forked monitor pops on out_valid.
module tb_fir_mac_mc;

  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int TAPS = 32;
  localparam int CH   = 2;

  logic                  clk;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [0:0]            in_ch;
  logic signed [DW-1:0]  x_in;
  logic                  bank_sel;
  logic                  coef_we;
  logic                  coef_bank;
  logic [4:0]            coef_addr;
  logic signed [CW-1:0]  coef_data;
  logic                  coef_err;
  logic                  out_valid;
  logic [0:0]            out_ch;
  logic signed [DW-1:0]  y_out;
  logic                  sat;

  fir_mac_mc #(.DW(DW), .CW(CW), .TAPS(TAPS), .CH(CH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .x_in      (x_in),
    .bank_sel  (bank_sel),
    .coef_we   (coef_we),
    .coef_bank (coef_bank),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .coef_err  (coef_err),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .y_out     (y_out),
    .sat       (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     ch;
    longint y;
    bit     sat;
    int     cyc;
  } exp_t;

  exp_t   sb[$];
  longint hist [CH][TAPS];
  longint coef [2][TAPS];
  int     checks = 0;
  int     errors = 0;
  bit     busy = 1'b0;
  int     act_edge = 0;
  bit     act_bank = 1'b0;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_clear();
    for (int c = 0; c < CH; c++)
      for (int t = 0; t < TAPS; t++) hist[c][t] = 0;
    for (int b = 0; b < 2; b++)
      for (int t = 0; t < TAPS; t++) coef[b][t] = 0;
  endfunction

  // Reference: y = clamp(floor((sum x[k]h[k] + 2^(CW-2)) / 2^(CW-1)))
  function automatic exp_t model_accept(int ch, logic [DW-1:0] x, bit bank);
    exp_t   e;
    longint acc, num, d, q, hi, lo;
    for (int t = TAPS - 1; t > 0; t--) hist[ch][t] = hist[ch][t-1];
    hist[ch][0] = longint'($signed(x));
    acc = 0;
    for (int t = 0; t < TAPS; t++) acc += hist[ch][t] * coef[bank][t];
    num = acc + (longint'(1) << (CW - 2));
    d   = longint'(1) << (CW - 1);
    q   = num / d;
    if ((num % d != 0) && (num < 0)) q = q - 1;
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -(longint'(1) << (DW - 1));
    e.ch  = ch;
    e.sat = 1'b0;
    if (q > hi) begin
      q = hi; e.sat = 1'b1;
    end else if (q < lo) begin
      q = lo; e.sat = 1'b1;
    end
    e.y   = q;
    e.cyc = 0;
    return e;
  endfunction

  task automatic send(int ch, logic [DW-1:0] x, bit bank, bit expect_out);
    int   n = 0;
    exp_t e;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout actual 0 required 1 (cycle %0d)", cyc);
      return;
    end
    in_valid = 1'b1;
    in_ch    = 1'(ch);
    x_in     = x;
    bank_sel = bank;
    act_edge = cyc + 1;
    act_bank = bank;
    busy     = 1'b1;
    e = model_accept(ch, x, bank);
    e.cyc = act_edge + TAPS + 1;
    if (expect_out) sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic coef_write(bit bank, int addr, logic [CW-1:0] data);
    bit conflict;
    int e;
    e = cyc + 1;
    conflict = busy && (bank == act_bank) && (e >= act_edge + 1) && (e <= act_edge + TAPS + 1);
    coef_we   = 1'b1;
    coef_bank = bank;
    coef_addr = 5'(addr);
    coef_data = data;
    @(negedge clk);
    coef_we = 1'b0;
    chk("coef_err", coef_err, conflict);
    if (!conflict) coef[bank][addr] = longint'($signed(data));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    busy = 1'b0;
  endtask

  task automatic check_idle_outputs();
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ch",    out_ch,    0);
    chk("rst_y_out",     y_out,     0);
    chk("rst_sat",       sat,       0);
    chk("rst_coef_err",  coef_err,  0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < TAPS * 4) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain pending %0d required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic load_ramp(bit bank);
    for (int k = 0; k < TAPS; k++) coef_write(bank, k, 16'(2 * (k + 1)));
  endtask

  task automatic impulse_ch0();
    for (int i = 0; i < TAPS; i++) send(0, (i == 0) ? 16'h4000 : 16'h0000, 1'b0, 1'b1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_ch = 1'b0; x_in = '0; bank_sel = 1'b0;
    coef_we = 1'b0; coef_bank = 1'b0; coef_addr = '0; coef_data = '0;
    model_clear();

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (out_valid) begin
            if (sb.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_out ch %0d y %0d (none required) cycle %0d", out_ch, y_out, cyc);
            end else begin
              e = sb.pop_front();
              chk("out_ch",    out_ch,          e.ch);
              chk("y_out",     $signed(y_out),  e.y);
              chk("sat",       sat,             e.sat);
              chk("out_cycle", cyc,             e.cyc);
            end
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_idle_outputs();

    // Impulse through bank 0 ramp: expect 1..TAPS.
    load_ramp(1'b0);
    impulse_ch0();
    drain();

    // Channel isolation: ch1 zeros interleaved with ch0 impulse.
    do_reset();
    load_ramp(1'b0);
    for (int i = 0; i < TAPS; i++) begin
      send(0, (i == 0) ? 16'h4000 : 16'h0000, 1'b0, 1'b1);
      send(1, 16'h0000, 1'b0, 1'b1);
    end
    drain();

    // Saturation both directions.
    do_reset();
    for (int k = 0; k < TAPS; k++) coef_write(1'b0, k, 16'h7FFF);
    for (int i = 0; i < TAPS; i++) send(0, 16'h7FFF, 1'b0, 1'b1);
    drain();
    for (int i = 0; i < TAPS; i++) send(0, 16'h8000, 1'b0, 1'b1);
    drain();

    // Bank 1 single tap with rounding.
    do_reset();
    coef_write(1'b1, 0, 16'h7FFF);
    send(0, 16'h1000, 1'b1, 1'b1);
    drain();

    // Write conflicts during MAC.
    do_reset();
    load_ramp(1'b0);
    send(0, 16'h4000, 1'b0, 1'b1);
    drain();
    send(0, 16'h4000, 1'b0, 1'b1);
    coef_write(1'b0, 1, 16'h1234);
    coef_write(1'b1, 5, 16'h0100);
    drain();

    // Randomised traffic with random coefficient writes.
    do_reset();
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < TAPS; k++) coef_write(1'(b), k, 16'($urandom_range(0, 1023) - 512));
    for (int i = 0; i < 60; i++) begin
      send($urandom_range(0, CH - 1), 16'($urandom), 1'($urandom), 1'b1);
      if ($urandom_range(0, 1) == 1)
        coef_write(1'($urandom), $urandom_range(0, TAPS - 1), 16'($urandom_range(0, 1023) - 512));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    // Reset mid-MAC aborts the sample.
    send(0, 16'h4000, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    do_reset();
    check_idle_outputs();
    repeat (TAPS + 5) @(negedge clk);
    load_ramp(1'b0);
    impulse_ch0();
    drain();

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
